// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection.
//
// Captures the decoded ID instruction into the EX stage on every rising edge.
// When the instruction in EX is a load whose destination is read by the ID
// instruction, a bubble is inserted instead and hazard_stall asks the front
// end to hold PC and IF/ID for that cycle. A flush discards the ID
// instruction and overrides the stall.
//
// Ports
//   clk, reset                  clock, async active-high reset
//   id_*                        decoded ID instruction (regs, operands, control)
//   flush                       discard ID instruction (taken branch/jump)
//   ex_*                        registered EX-stage copy of the instruction
//   hazard_stall                combinational load-use stall request
//   stall_count                 saturating count of inserted bubbles
module id_ex_hazard_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [4:0]            id_rs,
  input  logic [4:0]            id_rt,
  input  logic [4:0]            id_dest,
  input  logic                  id_uses_rt,
  input  logic [DATA_WIDTH-1:0] id_read_data_1,
  input  logic [DATA_WIDTH-1:0] id_read_data_2,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_alu_src,
  input  logic [3:0]            id_alu_op,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [4:0]            ex_rs,
  output logic [4:0]            ex_rt,
  output logic [4:0]            ex_dest,
  output logic [DATA_WIDTH-1:0] ex_read_data_1,
  output logic [DATA_WIDTH-1:0] ex_read_data_2,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_alu_src,
  output logic [3:0]            ex_alu_op,
  output logic                  hazard_stall,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  typedef struct packed {
    logic                  valid;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            dest;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] imm;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  alu_src;
    logic [3:0]            alu_op;
  } ex_t;

  ex_t                 ex_q, ex_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 dep_rs, dep_rt;

  // Load-use detection. $0 is hardwired zero, so a load targeting it never
  // produces a real dependency. Flush masks the stall so a discarded
  // instruction cannot freeze the front end.
  assign dep_rs = (ex_q.dest == id_rs);
  assign dep_rt = id_uses_rt & (ex_q.dest == id_rt);
  assign hazard_stall = ex_q.valid & ex_q.mem_read & (ex_q.dest != 5'd0) &
                        (dep_rs | dep_rt) & id_valid & ~flush;

  // One action per edge: flush, then bubble, then load. Flush, bubble and a
  // non-valid ID all collapse to the all-zero EX entry, which keeps
  // ex_reg_write low so the forwarding unit never matches a non-instruction.
  always_comb begin
    ex_d = '0;
    if (!flush && !hazard_stall && id_valid) begin
      ex_d.valid      = 1'b1;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.dest       = id_dest;
      ex_d.rd1        = id_read_data_1;
      ex_d.rd2        = id_read_data_2;
      ex_d.imm        = id_imm;
      ex_d.reg_write  = id_reg_write;
      ex_d.mem_read   = id_mem_read;
      ex_d.mem_write  = id_mem_write;
      ex_d.mem_to_reg = id_mem_to_reg;
      ex_d.alu_src    = id_alu_src;
      ex_d.alu_op     = id_alu_op;
    end
  end

  // Saturating bubble counter; hazard_stall already excludes flush cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (hazard_stall && (cnt_q != {CNT_WIDTH{1'b1}}))
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid       = ex_q.valid;
  assign ex_rs          = ex_q.rs;
  assign ex_rt          = ex_q.rt;
  assign ex_dest        = ex_q.dest;
  assign ex_read_data_1 = ex_q.rd1;
  assign ex_read_data_2 = ex_q.rd2;
  assign ex_imm         = ex_q.imm;
  assign ex_reg_write   = ex_q.reg_write;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_mem_write   = ex_q.mem_write;
  assign ex_mem_to_reg  = ex_q.mem_to_reg;
  assign ex_alu_src     = ex_q.alu_src;
  assign ex_alu_op      = ex_q.alu_op;
  assign stall_count    = cnt_q;

endmodule

// File: doc/id_ex_hazard_stage.md
ID_EX_HAZARD_STAGE -- requirements
Module: id_ex_hazard_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of register-file operands and immediate.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the load-use stall counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 id_valid  input  1  ID stage holds a real instruction.
REQ-006 id_rs, id_rt, id_dest  input  5 each  ID source registers and resolved destination register.
REQ-007 id_uses_rt  input  1  ID instruction reads rt as a source.
REQ-008 id_read_data_1, id_read_data_2, id_imm  input  DATA_WIDTH each  register-file outputs and sign-extended immediate.
REQ-009 id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src  input  1 each  ID control bits.
REQ-010 id_alu_op  input  4  ID ALU operation code.
REQ-011 flush  input  1  discard the ID instruction (taken branch/jump).
REQ-012 ex_valid, ex_rs, ex_rt, ex_dest, ex_read_data_1, ex_read_data_2, ex_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op  output  widths as ID counterparts  registered EX-stage copies; ex_rs/ex_rt/ex_dest/ex_reg_write feed the forwarding unit.
REQ-013 hazard_stall  output  1  combinational; freeze PC and IF/ID this cycle.
REQ-014 stall_count  output  CNT_WIDTH  registered count of inserted load-use bubbles.

Function
REQ-015 hazard_stall SHALL equal ex_valid & ex_mem_read & (ex_dest != 0) & ((ex_dest == id_rs) | (id_uses_rt & ex_dest == id_rt)) & id_valid & ~flush.
REQ-016 Each rising edge SHALL apply exactly one action, priority: flush, then bubble (hazard_stall=1), then load.
REQ-017 Load: every ex_* output SHALL take its id_* counterpart; ex_valid <= id_valid.
REQ-018 Bubble and flush: ex_valid, all control bits, ex_alu_op, ex_rs, ex_rt and ex_dest SHALL become 0; data fields SHALL become 0.
REQ-019 id_valid=0 on load SHALL produce the same zeroed control as a bubble (ex_reg_write forced 0), so the forwarding unit never matches a non-instruction.
REQ-020 Latency SHALL be exactly one cycle ID to EX; no internal buffering beyond one entry.
REQ-021 Load-use stall SHALL last exactly one cycle per load: the bubble clears ex_mem_read, so hazard_stall drops the next cycle with unchanged ID inputs.
REQ-022 stall_count SHALL increment by 1 on each edge where a bubble is inserted and SHALL saturate at all-ones (no wrap).
REQ-023 Flush and hazard condition in the same cycle: flush wins, hazard_stall=0, stall_count unchanged.
REQ-024 Register $0 SHALL never trigger a stall, even when ex_mem_read=1 and id_rs=0.
REQ-025 Two consecutive loads to the same register SHALL each be evaluated independently; a second dependent instruction after the bubble loads normally.

Reset
REQ-026 On reset assertion, all ex_* outputs and stall_count SHALL go to 0 without waiting for clk; hazard_stall therefore reads 0.
REQ-027 Reset mid-stall SHALL cancel the pending bubble; first edge after release performs a normal load.
REQ-028 Reset release SHALL be synchronous to clk by the surrounding system; the block adds no synchronizer.

Verification
REQ-029 Reset: assert reset with nonzero ex state -> all outputs 0 immediately, stall_count=0.
REQ-030 Pass-through: id_rs=3, id_rt=4, id_dest=5, id_reg_write=1, id_read_data_1=0x1234 -> next edge ex_rs=3, ex_dest=5, ex_reg_write=1, ex_read_data_1=0x1234, hazard_stall=0.
REQ-031 Load-use: EX holds lw ex_dest=8, ex_mem_read=1; ID add id_rs=8 -> hazard_stall=1, next edge ex_valid=0, ex_reg_write=0, stall_count=1; following cycle hazard_stall=0 and add loads.
REQ-032 rt gating: ex_dest=9 mem_read, id_rt=9, id_uses_rt=0 -> hazard_stall=0; id_uses_rt=1 -> hazard_stall=1.
REQ-033 Flush priority: load-use condition plus flush=1 -> hazard_stall=0, next edge EX zeroed, stall_count unchanged.
REQ-034 Saturation: preload/force 0xFFFF bubbles -> stall_count holds 0xFFFF after further bubbles; $0 case ex_dest=0 mem_read, id_rs=0 -> no stall.
